shift_unit_iter: RTL and testbench
==================================

// Module: shift_unit_iter
// PURPOSE
//  Parametrised, multi-cycle shift unit.
//  - Executes SLL/SRL/SRA (and ROR when enabled) by shifting STEP bits per clock.
//  - Trades latency for area compared with the single-cycle combinational shifter.
//  - Sits in the execute stage beside the ALU.
//  - Uses a valid/ready handshake on both sides, so the pipeline stalls while it is busy.
// PARAMETERS
//  XLEN  32  datapath width; power of 2, >= 8
//  STEP  1   bits shifted per cycle; power of 2, 1 <= STEP <= XLEN
// PORTS
//  clk_i        in   1        clock, all state on rising edge
//  rst_i        in   1        synchronous reset, active-high
//  valid_i      in   1        request valid
//  ready_o      out  1        unit can accept a request
//  op_i         in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR (see CONFIGURATION)
//  operand_a_i  in   XLEN     value to shift
//  operand_b_i  in   XLEN     shift amount; only [$clog2(XLEN)-1:0] used, upper bits ignored
//  flush_i      in   1        abort any in-flight operation
//  valid_o      out  1        result_o holds a completed result
//  ready_i      in   1        consumer accepts result
//  result_o     out  XLEN     shifted value
// BEHAVIOUR
//  - Reset: state=IDLE, valid_o=0, result_o=0, internal counter=0.
//    - ready_o=0 while rst_i=1; ready_o=1 in the first cycle after reset deasserts.
//  - FSM states: IDLE, SHIFT, DONE.
//    - ready_o = (state==IDLE) && !rst_i.
//    - valid_o = (state==DONE).
//  - IDLE: on valid_i && ready_o at cycle T:
//    - latch op, operand_a -> acc, shamt = operand_b_i[$clog2(XLEN)-1:0] -> rem.
//    - If shamt==0: go to DONE, result_o = operand_a, valid_o=1 at T+1.
//    - Otherwise: go to SHIFT.
//  - SHIFT: each cycle s = min(STEP, rem).
//    - acc shifts by s: SLL zero-fill, SRL zero-fill, SRA sign-fill from acc[XLEN-1], ROR rotate.
//    - rem -= s.
//    - When rem reaches 0, load result_o and go to DONE.
//  - Latency: valid_o asserted at T + 1 + ceil(shamt/STEP).
//  - SRA sign-fill uses the bit at acc[XLEN-1] every step. This gives the same result as
//    a single arithmetic shift by shamt.
//  - DONE: result_o and valid_o are held stable until ready_i=1.
//    - On valid_o && ready_i, go to IDLE. valid_o=0 and ready_o=1 next cycle.
//    - No same-cycle result-accept plus new-request; minimum issue interval is 2 cycles.
//  - flush_i (any state): next cycle state=IDLE, valid_o=0; the operation is discarded.
//    - A request presented with flush_i=1 in IDLE is not accepted.
//  - rst_i has priority over flush_i and all handshakes. Reset mid-SHIFT or mid-DONE
//    discards the operation; no valid_o is produced for it.
//  - In IDLE, input changes while ready_o=1 and valid_i=0 have no effect.
//  - Latched operands are insensitive to input changes after acceptance.
//  - result_o is held after leaving DONE. It is updated only on completion or reset.
//    It is undefined-but-stable to consumers when valid_o=0.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined:
//    - op 11 = ROR, rotate right by shamt, same per-step latency as the shifts.
//  SHIFT_ROTATE_EN undefined:
//    - op 11 is accepted, ignores shamt, and completes like shamt==0.
//    - result_o = operand_a_i, valid_o at T+1.
//    - No rotate logic is instantiated.
// TESTING
//  1 XLEN=32, STEP=1: SRA a=0x8000_0000, b=4, ready_i=1
//    -> result 0xF800_0000, valid_o at T+5, ready_o=1 at T+6.
//  2 STEP=4: SLL a=0x0000_0001, b=31 -> 0x8000_0000 at T+9 (8 SHIFT cycles).
//    SRL a=0xFFFF_FFFF, b=0x25 (uses 5) -> 0x07FF_FFFF at T+3.
//  3 b=0 on any op -> result=a at T+1.
//    Hold ready_i=0 for 5 cycles -> valid_o and result stay stable, ready_o=0 throughout.
//  4 flush_i pulsed during SHIFT of SLL by 20 (STEP=1) -> valid_o never asserts, ready_o=1 next cycle.
//    rst_i pulsed in DONE -> valid_o=0 and result_o=0 next cycle.
//  5 op=11, a=0x0000_00F1, b=4:
//    - with SHIFT_ROTATE_EN -> 0x1000_000F.
//    - without it -> 0x0000_00F1 at T+1.
//  6 Random regression: 10k ops across XLEN in {16,32,64} and STEP in {1,2,8,XLEN}.
//    - Results compared against a <<, >>, >>>, rotate reference model.
//    - Latency checked against 1+ceil(shamt/STEP).

Source files
------------

// File: rtl/shift_unit_iter.sv
// rtl/shift_unit_iter.sv - multi-cycle SLL/SRL/SRA shifter, STEP bits per clock; ROR when SHIFT_ROTATE_EN is defined
module shift_unit_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      op_q;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] shifted;
    logic [SW-1:0]   rem;
    logic [SW-1:0]   s;
    logic [SW-1:0]   shamt;
    logic            accept;
    logic            imm_done;
    logic            last;
    logic            unused_b;

    assign shamt    = operand_b_i[SW-1:0];
    assign unused_b = ^operand_b_i[XLEN-1:SW];
    assign ready_o  = (state == IDLE) && !rst_i;
    assign valid_o  = (state == DONE);
    assign accept   = valid_i && ready_o && !flush_i;

`ifdef SHIFT_ROTATE_EN
    assign imm_done = (shamt == '0);
`else
    // Without rotate support op 11 passes operand_a straight through.
    assign imm_done = (shamt == '0) || (op_i == 2'b11);
`endif

    // rem is always below XLEN, so s never needs the full STEP==XLEN value.
    assign s    = ({1'b0, rem} >= STEP_W) ? STEP_W[SW-1:0] : rem;
    assign last = (rem == s);

`ifdef SHIFT_ROTATE_EN
    logic [SW-1:0] lamt;
    assign lamt = -s;
`endif

    always_comb begin
        shifted = acc;
        case (op_q)
            2'b00:   shifted = acc << s;
            2'b01:   shifted = acc >> s;
            2'b10:   shifted = $signed(acc) >>> s;
`ifdef SHIFT_ROTATE_EN
            2'b11:   shifted = (acc >> s) | (acc << lamt);
`endif
            default: shifted = acc;
        endcase
    end

    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = imm_done ? DONE : SHIFT;
                SHIFT:   if (last) state_next = DONE;
                DONE:    if (ready_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op_q     <= '0;
            acc      <= '0;
            rem      <= '0;
            result_o <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= op_i;
                acc  <= operand_a_i;
                rem  <= shamt;
                if (imm_done) result_o <= operand_a_i;
            end else if (state == SHIFT && !flush_i) begin
                acc <= shifted;
                rem <= rem - s;
                if (last) result_o <= shifted;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// tb/tb_shift_unit_iter.sv - table-driven bench for shift_unit_iter at STEP=1 and STEP=4
module tb_shift_unit_iter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] operand_a_i = '0;
    logic [31:0] operand_b_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_i = 1'b1;

    logic        ready1, valid1, ready4, valid4;
    logic [31:0] res1, res4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_unit_iter #(.XLEN(32), .STEP(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready1),
        .op_i(op_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .flush_i(flush_i), .valid_o(valid1), .ready_i(ready_i), .result_o(res1)
    );

    shift_unit_iter #(.XLEN(32), .STEP(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready4),
        .op_i(op_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .flush_i(flush_i), .valid_o(valid4), .ready_i(ready_i), .result_o(res4)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b, input int step);
        int sh;
        sh = int'(b[4:0]);
`ifndef SHIFT_ROTATE_EN
        if (op == 2'b11) return 1;
`endif
        return 1 + (sh + step - 1) / step;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int got1, got4;
        logic [31:0] r1, r4;
        got1 = 0;
        got4 = 0;
        r1 = '0;
        r4 = '0;
        @(negedge clk);
        op_i = v.op;
        operand_a_i = v.a;
        operand_b_i = v.b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        operand_a_i = ~v.a;
        operand_b_i = v.b ^ 32'h1F;
        op_i = ~v.op;
        for (int c = 1; c <= 80 && (got1 == 0 || got4 == 0); c++) begin
            @(negedge clk);
            if (got1 == 0 && valid1) begin got1 = c; r1 = res1; end
            if (got4 == 0 && valid4) begin got4 = c; r4 = res4; end
        end
        chk($sformatf("v%0d result step1", idx), 64'(r1), 64'(v.exp));
        chk($sformatf("v%0d latency step1", idx), 64'(got1), 64'(exp_lat(v.op, v.b, 1)));
        chk($sformatf("v%0d result step4", idx), 64'(r4), 64'(v.exp));
        chk($sformatf("v%0d latency step4", idx), 64'(got4), 64'(exp_lat(v.op, v.b, 4)));
        @(negedge clk);
        chk($sformatf("v%0d ready after", idx), {62'd0, ready1, ready4}, 64'd3);
        chk($sformatf("v%0d valid after", idx), {62'd0, valid1, valid4}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{2'b10, 32'h8000_0000, 32'd4,     32'hF800_0000};
        vecs[1]  = '{2'b00, 32'h0000_0001, 32'd31,    32'h8000_0000};
        vecs[2]  = '{2'b01, 32'hFFFF_FFFF, 32'h25,    32'h07FF_FFFF};
        vecs[3]  = '{2'b00, 32'h1234_5678, 32'd0,     32'h1234_5678};
        vecs[4]  = '{2'b10, 32'h7FFF_FFFF, 32'd8,     32'h007F_FFFF};
        vecs[5]  = '{2'b10, 32'h8000_0001, 32'd31,    32'hFFFF_FFFF};
        vecs[6]  = '{2'b01, 32'h8000_0000, 32'd31,    32'h0000_0001};
        vecs[7]  = '{2'b00, 32'hA5A5_A5A5, 32'd4,     32'h5A5A_5A50};
        vecs[8]  = '{2'b10, 32'hF000_0000, 32'h104,   32'hFF00_0000};
        vecs[9]  = '{2'b01, 32'h1234_5678, 32'd12,    32'h0001_2345};
        vecs[10] = '{2'b10, 32'h8765_4321, 32'd3,     32'hF0EC_A864};
`ifdef SHIFT_ROTATE_EN
        vecs[11] = '{2'b11, 32'h0000_00F1, 32'd4,     32'h1000_000F};
        vecs[12] = '{2'b11, 32'h1234_5678, 32'd8,     32'h7812_3456};
`else
        vecs[11] = '{2'b11, 32'h0000_00F1, 32'd4,     32'h0000_00F1};
        vecs[12] = '{2'b11, 32'h1234_5678, 32'd8,     32'h1234_5678};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready1", 64'(ready1), 64'd0);
        chk("reset ready4", 64'(ready4), 64'd0);
        chk("reset valid1", 64'(valid1), 64'd0);
        chk("reset result1", 64'(res1), 64'd0);
        chk("reset result4", 64'(res4), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("post-reset ready1", 64'(ready1), 64'd1);
        chk("post-reset ready4", 64'(ready4), 64'd1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Consumer back-pressure: result and valid held, no new request accepted
        @(negedge clk);
        ready_i = 1'b0;
        op_i = 2'b00;
        operand_a_i = 32'hCAFE_BABE;
        operand_b_i = 32'd0;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        operand_a_i = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold%0d valid", k), {62'd0, valid1, valid4}, 64'd3);
            chk($sformatf("hold%0d ready", k), {62'd0, ready1, ready4}, 64'd0);
            chk($sformatf("hold%0d result1", k), 64'(res1), 64'hCAFE_BABE);
            chk($sformatf("hold%0d result4", k), 64'(res4), 64'hCAFE_BABE);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        chk("hold release valid", {62'd0, valid1, valid4}, 64'd0);
        chk("hold release ready", {62'd0, ready1, ready4}, 64'd3);

        // Flush mid-SHIFT of SLL by 20
        @(negedge clk);
        op_i = 2'b00;
        operand_a_i = 32'h1;
        operand_b_i = 32'd20;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-flush busy", {62'd0, ready1, ready4}, 64'd0);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush ready", {62'd0, ready1, ready4}, 64'd3);
        chk("flush valid", {62'd0, valid1, valid4}, 64'd0);
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (valid1 || valid4) seen = 1;
            end
            chk("flush no late valid", 64'(seen), 64'd0);
        end
        chk("flush result held", 64'(res1), 64'hCAFE_BABE);

        // Request with flush_i high in IDLE is dropped
        @(negedge clk);
        operand_a_i = 32'h5;
        operand_b_i = 32'd0;
        valid_i = 1'b1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        chk("idle flush valid", {62'd0, valid1, valid4}, 64'd0);
        chk("idle flush ready", {62'd0, ready1, ready4}, 64'd3);

        // Reset while in DONE
        ready_i = 1'b0;
        operand_a_i = 32'hDEAD_BEEF;
        operand_b_i = 32'd0;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        chk("pre-reset done valid", {62'd0, valid1, valid4}, 64'd3);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("done reset valid", {62'd0, valid1, valid4}, 64'd0);
        chk("done reset result1", 64'(res1), 64'd0);
        chk("done reset result4", 64'(res4), 64'd0);
        ready_i = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
